fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// imem_req/imem_addr are held stable until imem_ack.
// imem_ack qualifies imem_rdata only in a cycle where imem_req is high.
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word reads and feeds the decoder.
// Has a one-word skid buffer, inserts bubbles, and honours downstream stall.
module fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] NOP_INSTR = 32'h0400001F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    fetch_unit_if.master      imem,
    output logic [31:0]       instruction_memory,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       fetch_count,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    logic              req_q;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_word;
    logic [15:0]       count_q;
    logic [15:0]       count_next;
    logic              ack_seen;

    // Saturating delivered-instruction counter.
    assign count_next = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign ack_seen   = req_q && imem.imem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            req_q              <= 1'b0;
            pc                 <= '0;
            pc_out             <= '0;
            buf_addr           <= '0;
            buf_word           <= NOP_INSTR;
            instruction_memory <= NOP_INSTR;
            instr_valid        <= 1'b0;
            count_q            <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (ack_seen && !stall) begin
                        instruction_memory <= imem.imem_rdata;
                        instr_valid        <= 1'b1;
                        pc_out             <= pc;
                        pc                 <= pc + 1'b1;
                        count_q            <= count_next;
                    end else if (ack_seen && stall) begin
                        // Decoder is blocked: park the word and stop fetching.
                        buf_word <= imem.imem_rdata;
                        buf_addr <= pc;
                        pc       <= pc + 1'b1;
                        state    <= HOLD;
                        req_q    <= 1'b0;
                    end else if (!stall) begin
                        instruction_memory <= NOP_INSTR;
                        instr_valid        <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instruction_memory <= buf_word;
                        pc_out             <= buf_addr;
                        instr_valid        <= 1'b1;
                        count_q            <= count_next;
                        state              <= REQ;
                        req_q              <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign fetch_count    = count_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/hold, bubbles, wrap,
// reset during HOLD and counter saturation.
module tb_fetch_unit;

    localparam int          ADDR_W = 8;
    localparam logic [31:0] NOP    = 32'h0400001F;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_REQ  = 2'd1;
    localparam logic [1:0]  ST_HOLD = 2'd2;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic [31:0]       instruction_memory;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_out;
    logic [15:0]       fetch_count;
    logic [1:0]        state_dbg;

    int n_checks;
    int n_pass;
    logic [31:0] exp_q[$];

    fetch_unit_if #(.ADDR_W(ADDR_W)) imem_bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .imem               (imem_bus),
        .instruction_memory (instruction_memory),
        .instr_valid        (instr_valid),
        .pc_out             (pc_out),
        .fetch_count        (fetch_count),
        .state_dbg          (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return 32'h04000000 | ({24'd0, a} << 11) | 32'd32;
    endfunction

    // Memory model: returns the word for whatever address is presented.
    always_comb imem_bus.imem_rdata = word_of(imem_bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im"},    instruction_memory, NOP);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_pcout"}, {24'd0, pc_out}, 32'd0);
        check({tag, "_req"},   {31'd0, imem_bus.imem_req}, 32'd0);
        check({tag, "_addr"},  {24'd0, imem_bus.imem_addr}, 32'd0);
        check({tag, "_count"}, {16'd0, fetch_count}, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, ST_IDLE});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        imem_bus.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_to_req_state", {30'd0, state_dbg}, {30'd0, ST_REQ});
        check("idle_to_req_req", {31'd0, imem_bus.imem_req}, 32'd1);
        check("first_addr", {24'd0, imem_bus.imem_addr}, 32'd0);

        // Back-to-back acks: one word per cycle, addresses 0..4.
        imem_bus.imem_ack = 1'b1;
        for (int a = 0; a < 5; a++) begin
            @(negedge clk);
            check("stream_word", instruction_memory, word_of(8'(a)));
            check("stream_pcout", {24'd0, pc_out}, a);
            check("stream_valid", {31'd0, instr_valid}, 32'd1);
            check("stream_addr", {24'd0, imem_bus.imem_addr}, a + 1);
            if (a == 2) check("count_after_3", {16'd0, fetch_count}, 32'd3);
        end

        // Ack at addr 5 under stall: park in HOLD for 4 cycles; acks ignored.
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("hold_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
            check("hold_state", {30'd0, state_dbg}, {30'd0, ST_HOLD});
            check("hold_im_kept", instruction_memory, word_of(8'd4));
            check("hold_pcout_kept", {24'd0, pc_out}, 32'd4);
            check("hold_count", {16'd0, fetch_count}, 32'd5);
        end
        stall = 1'b0;
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        check("release_word5", instruction_memory, word_of(8'd5));
        check("release_pcout", {24'd0, pc_out}, 32'd5);
        check("release_valid", {31'd0, instr_valid}, 32'd1);
        check("release_count", {16'd0, fetch_count}, 32'd6);
        check("release_next_addr", {24'd0, imem_bus.imem_addr}, 32'd6);
        check("release_req", {31'd0, imem_bus.imem_req}, 32'd1);

        // No ack for 3 cycles: bubbles, address held.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bubble_im", instruction_memory, NOP);
            check("bubble_valid", {31'd0, instr_valid}, 32'd0);
            check("bubble_addr", {24'd0, imem_bus.imem_addr}, 32'd6);
        end

        imem_bus.imem_ack = 1'b1;
        @(negedge clk);
        check("word6_no_dup", instruction_memory, word_of(8'd6));
        check("word6_count", {16'd0, fetch_count}, 32'd7);

        // Stall with no ack in REQ: outputs frozen, request stays up.
        stall = 1'b1;
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        check("stall_noack_im", instruction_memory, word_of(8'd6));
        check("stall_noack_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_noack_req", {31'd0, imem_bus.imem_req}, 32'd1);
        check("stall_noack_addr", {24'd0, imem_bus.imem_addr}, 32'd7);

        // Stream 7..254, then wrap at 255.
        stall = 1'b0;
        imem_bus.imem_ack = 1'b1;
        for (int a = 7; a < 255; a++) begin
            exp_q.push_back(word_of(8'(a)));
            @(negedge clk);
            check("long_stream", instruction_memory, exp_q.pop_front());
        end
        check("pre_wrap_addr", {24'd0, imem_bus.imem_addr}, 32'd255);
        @(negedge clk);
        check("wrap_word", instruction_memory, word_of(8'd255));
        check("wrap_pcout", {24'd0, pc_out}, 32'd255);
        check("wrap_addr", {24'd0, imem_bus.imem_addr}, 32'd0);
        check("wrap_count", {16'd0, fetch_count}, 32'd256);

        // Fetch 0..8, then park word 9 in HOLD and reset mid-cycle.
        repeat (9) @(negedge clk);
        check("pre_hold9_addr", {24'd0, imem_bus.imem_addr}, 32'd9);
        stall = 1'b1;
        @(negedge clk);
        check("hold9_state", {30'd0, state_dbg}, {30'd0, ST_HOLD});
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        check("post_reset_addr", {24'd0, imem_bus.imem_addr}, 32'd0);
        check("post_reset_req", {31'd0, imem_bus.imem_req}, 32'd1);
        imem_bus.imem_ack = 1'b1;
        @(negedge clk);
        check("post_reset_word0", instruction_memory, word_of(8'd0));
        check("post_reset_pcout", {24'd0, pc_out}, 32'd0);
        check("post_reset_count", {16'd0, fetch_count}, 32'd1);

        // Counter saturation from 16'hFFFE.
        force dut.count_q = 16'hFFFE;
        #1 release dut.count_q;
        check("preload_count", {16'd0, fetch_count}, 32'h0000FFFE);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("sat_count", {16'd0, fetch_count}, 32'h0000FFFF);
        end
        check("sat_last_word", instruction_memory, word_of(8'd3));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
